// File: rtl/ixu_mc_sched.sv
// Multi-cycle integer port sequencer: dispatches to the pipelined multiplier and the
// iterative divider, and arbitrates the shared writeback port. Optional perf counters: IXU_MC_PERF_EN.
module ixu_mc_sched #(
  parameter int MUL_LAT = 3,
  parameter int PERF_W  = 32
) (
  input  logic              core_clock_i,
  input  logic              core_reset_i,
  input  logic              core_flush_i,
  input  logic              mc_vld_i,
  input  logic [17:0]       mc_data_i,
  input  logic [2:0]        mc_op_i,
  output logic              mc_busy_o,
  output logic              mul_vld_o,
  output logic [1:0]        mul_op_o,
  output logic [5:0]        mul_rs1_o,
  output logic [5:0]        mul_rs2_o,
  output logic              div_start_o,
  output logic [1:0]        div_op_o,
  output logic [5:0]        div_rs1_o,
  output logic [5:0]        div_rs2_o,
  output logic              div_kill_o,
  input  logic              div_done_i,
  output logic              div_ack_o,
  output logic              wb_vld_o,
  output logic [5:0]        wb_rob_o,
  output logic              wb_sel_o
`ifdef IXU_MC_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_mul_o,
  output logic [PERF_W-1:0] perf_div_o,
  output logic [PERF_W-1:0] perf_busy_o
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  if (MUL_LAT < 1 || MUL_LAT > 8 || PERF_W < 1) begin : g_param_check
    $error("ixu_mc_sched: MUL_LAT must be 1..8 and PERF_W at least 1");
  end

  state_t     state_reg;
  state_t     state_next;
  logic       accept;
  logic       accept_mul;
  logic       accept_div;
  logic [5:0] mul_rob_reg;
  logic [5:0] div_rob_reg;
  logic       pipe_vld_reg [1:MUL_LAT];
  logic [5:0] pipe_rob_reg [1:MUL_LAT];
  logic       pipe_out_vld;
  logic [5:0] pipe_out_rob;

  // New ops are only taken while idle; anything offered during RUN is a protocol error.
  assign accept     = mc_vld_i & ~core_flush_i & (state_reg == IDLE);
  assign accept_mul = accept & ~mc_op_i[2];
  assign accept_div = accept &  mc_op_i[2];

  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      mul_vld_o   <= 1'b0;
      mul_op_o    <= '0;
      mul_rs1_o   <= '0;
      mul_rs2_o   <= '0;
      mul_rob_reg <= '0;
      div_start_o <= 1'b0;
      div_op_o    <= '0;
      div_rs1_o   <= '0;
      div_rs2_o   <= '0;
      div_rob_reg <= '0;
      div_kill_o  <= 1'b0;
    end else begin
      mul_vld_o   <= accept_mul;
      div_start_o <= accept_div;
      div_kill_o  <= core_flush_i & (state_reg == RUN);
      if (accept_mul) begin
        mul_op_o    <= mc_op_i[1:0];
        mul_rs1_o   <= mc_data_i[11:6];
        mul_rs2_o   <= mc_data_i[17:12];
        mul_rob_reg <= mc_data_i[5:0];
      end
      if (accept_div) begin
        div_op_o    <= mc_op_i[1:0];
        div_rs1_o   <= mc_data_i[11:6];
        div_rs2_o   <= mc_data_i[17:12];
        div_rob_reg <= mc_data_i[5:0];
      end
    end
  end

  // Stage gi holds the multiply dispatched gi cycles ago; the last stage is the writeback slot.
  for (genvar gi = 1; gi <= MUL_LAT; gi++) begin : g_pipe
    logic       src_vld;
    logic [5:0] src_rob;
    if (gi == 1) begin : g_head
      assign src_vld = mul_vld_o;
      assign src_rob = mul_rob_reg;
    end else begin : g_body
      assign src_vld = pipe_vld_reg[gi-1];
      assign src_rob = pipe_rob_reg[gi-1];
    end
    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
        pipe_vld_reg[gi] <= 1'b0;
        pipe_rob_reg[gi] <= '0;
      end else begin
        pipe_vld_reg[gi] <= src_vld & ~core_flush_i;
        pipe_rob_reg[gi] <= src_rob;
      end
    end
  end

  assign pipe_out_vld = pipe_vld_reg[MUL_LAT];
  assign pipe_out_rob = pipe_rob_reg[MUL_LAT];

  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) state_reg <= IDLE;
    else              state_reg <= state_next;
  end

  // The multiplier owns the writeback slot when occupied; the divider result waits at most MUL_LAT cycles.
  always_comb begin
    state_next = state_reg;
    wb_vld_o   = 1'b0;
    wb_sel_o   = 1'b0;
    wb_rob_o   = '0;
    div_ack_o  = 1'b0;
    case (state_reg)
      IDLE: if (accept_div) state_next = RUN;
      RUN: begin
        if (core_flush_i) begin
          state_next = IDLE;
        end else if (div_done_i && !pipe_out_vld) begin
          wb_vld_o   = 1'b1;
          wb_sel_o   = 1'b1;
          wb_rob_o   = div_rob_reg;
          div_ack_o  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (pipe_out_vld && !core_flush_i) begin
      wb_vld_o = 1'b1;
      wb_sel_o = 1'b0;
      wb_rob_o = pipe_out_rob;
    end
  end

  assign mc_busy_o = (state_reg == RUN) | (mc_vld_i & mc_op_i[2]);

  a_no_issue_in_run: assert property (@(posedge core_clock_i) disable iff (core_reset_i)
    !(mc_vld_i && state_reg == RUN))
    else $error("ixu_mc_sched: op issued while divider is running");

`ifdef IXU_MC_PERF_EN
  logic [PERF_W-1:0] perf_mul_reg;
  logic [PERF_W-1:0] perf_div_reg;
  logic [PERF_W-1:0] perf_busy_reg;

  // Saturating counters survive flush; only reset clears them.
  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      perf_mul_reg  <= '0;
      perf_div_reg  <= '0;
      perf_busy_reg <= '0;
    end else begin
      if (accept_mul && !(&perf_mul_reg))  perf_mul_reg  <= perf_mul_reg + PERF_W'(1);
      if (accept_div && !(&perf_div_reg))  perf_div_reg  <= perf_div_reg + PERF_W'(1);
      if (mc_busy_o && !(&perf_busy_reg))  perf_busy_reg <= perf_busy_reg + PERF_W'(1);
    end
  end

  assign perf_mul_o  = perf_mul_reg;
  assign perf_div_o  = perf_div_reg;
  assign perf_busy_o = perf_busy_reg;
`endif

endmodule

// File: tb/tb_ixu_mc_sched.sv
// Scoreboard bench for ixu_mc_sched: dispatches and writebacks are queued when driven
// and checked by a negedge monitor; point checks cover busy, ack, kill and reset.
module tb_ixu_mc_sched;

  localparam int MUL_LAT = 3;

  typedef struct {
    int         cyc;
    logic       is_div;
    logic [1:0] op;
    logic [5:0] rs1;
    logic [5:0] rs2;
  } disp_t;

  typedef struct {
    int         cyc;
    logic [5:0] rob;
    logic       sel;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        mc_vld = 1'b0;
  logic [17:0] mc_data = '0;
  logic [2:0]  mc_op = '0;
  logic        div_done = 1'b0;
  logic        mc_busy, mul_vld, div_start, div_kill, div_ack, wb_vld, wb_sel;
  logic [1:0]  mul_op, div_op;
  logic [5:0]  mul_rs1, mul_rs2, div_rs1, div_rs2, wb_rob;
`ifdef IXU_MC_PERF_EN
  logic [31:0] perf_mul, perf_div, perf_busy;
`endif

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  disp_t dq[$];
  wb_t   wq[$];

  ixu_mc_sched #(.MUL_LAT(MUL_LAT), .PERF_W(32)) dut (
    .core_clock_i(clk),
    .core_reset_i(rst),
    .core_flush_i(flush),
    .mc_vld_i(mc_vld),
    .mc_data_i(mc_data),
    .mc_op_i(mc_op),
    .mc_busy_o(mc_busy),
    .mul_vld_o(mul_vld),
    .mul_op_o(mul_op),
    .mul_rs1_o(mul_rs1),
    .mul_rs2_o(mul_rs2),
    .div_start_o(div_start),
    .div_op_o(div_op),
    .div_rs1_o(div_rs1),
    .div_rs2_o(div_rs2),
    .div_kill_o(div_kill),
    .div_done_i(div_done),
    .div_ack_o(div_ack),
    .wb_vld_o(wb_vld),
    .wb_rob_o(wb_rob),
    .wb_sel_o(wb_sel)
`ifdef IXU_MC_PERF_EN
    ,
    .perf_mul_o(perf_mul),
    .perf_div_o(perf_div),
    .perf_busy_o(perf_busy)
`endif
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_wb(input int c, input logic [5:0] rob, input logic sel);
    wb_t w;
    w.cyc = c; w.rob = rob; w.sel = sel;
    wq.push_back(w);
  endtask

  // Presents one op for one cycle and records what the DUT should do with it.
  task automatic issue(input logic [2:0] op, input logic [5:0] rob, input logic [5:0] rs1,
                       input logic [5:0] rs2, input bit push_disp, input bit push_mwb,
                       input logic exp_busy);
    disp_t d;
    mc_vld  = 1'b1;
    mc_op   = op;
    mc_data = {rs2, rs1, rob};
    if (push_disp) begin
      d.cyc = cyc + 1; d.is_div = op[2]; d.op = op[1:0]; d.rs1 = rs1; d.rs2 = rs2;
      dq.push_back(d);
    end
    if (push_mwb) push_wb(cyc + 1 + MUL_LAT, rob, 1'b0);
    @(negedge clk);
    check("busy_accept", mc_busy, exp_busy);
    tick();
    mc_vld  = 1'b0;
    mc_op   = '0;
    mc_data = '0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mul_vld || div_start) begin
        if (dq.size() == 0) begin
          check("disp_unexpected", 1, 0);
        end else begin
          disp_t d;
          d = dq.pop_front();
          $display("disp cyc=%0d div=%0d op=%0d", cyc, div_start, mul_vld ? mul_op : div_op);
          check("disp_cyc", cyc, d.cyc);
          check("disp_kind", div_start, d.is_div);
          check("disp_op", d.is_div ? div_op : mul_op, d.op);
          check("disp_rs1", d.is_div ? div_rs1 : mul_rs1, d.rs1);
          check("disp_rs2", d.is_div ? div_rs2 : mul_rs2, d.rs2);
        end
      end
      if (wb_vld) begin
        if (wq.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          wb_t w;
          w = wq.pop_front();
          $display("wb   cyc=%0d rob=%02h sel=%0d", cyc, wb_rob, wb_sel);
          check("wb_cyc", cyc, w.cyc);
          check("wb_rob", wb_rob, w.rob);
          check("wb_sel", wb_sel, w.sel);
        end
      end
      if (div_ack || (wb_vld && wb_sel)) check("div_ack_wb", div_ack, wb_vld & wb_sel);
    end
  end

  initial begin
    tick();
    tick();
    @(negedge clk);
    check("rst_busy", mc_busy, 0);
    check("rst_mul_vld", mul_vld, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_kill", div_kill, 0);
    check("rst_wb_vld", wb_vld, 0);
    check("rst_wb_rob", wb_rob, 0);
    check("rst_div_ack", div_ack, 0);
    tick();
    rst = 1'b0;

    // single multiply
    goto(10);
    issue(3'b001, 6'h05, 6'h01, 6'h02, 1, 1, 1'b0);

    // back-to-back multiplies, busy stays low
    goto(20);
    issue(3'b000, 6'h01, 6'h0A, 6'h0B, 1, 1, 1'b0);
    issue(3'b010, 6'h02, 6'h0C, 6'h0D, 1, 1, 1'b0);
    issue(3'b011, 6'h03, 6'h0E, 6'h0F, 1, 1, 1'b0);

    // divide with a long latency
    goto(40);
    issue(3'b101, 6'h2A, 6'h10, 6'h20, 1, 0, 1'b1);
    goto(50);
    @(negedge clk);
    check("busy_run", mc_busy, 1);
    goto(75);
    div_done = 1'b1;
    push_wb(75, 6'h2A, 1'b1);
    @(negedge clk);
    check("div_ack", div_ack, 1);
    tick();
    div_done = 1'b0;
    @(negedge clk);
    check("busy_after_ack", mc_busy, 0);

    // writeback collision: multiply slot wins, divider follows next cycle
    goto(100);
    issue(3'b010, 6'h07, 6'h03, 6'h04, 1, 1, 1'b0);
    issue(3'b100, 6'h11, 6'h05, 6'h06, 1, 0, 1'b1);
    goto(104);
    div_done = 1'b1;
    @(negedge clk);
    check("ack_blocked", div_ack, 0);
    tick();
    push_wb(105, 6'h11, 1'b1);
    @(negedge clk);
    check("ack_after_slot", div_ack, 1);
    tick();
    div_done = 1'b0;
    @(negedge clk);
    check("busy_after_coll", mc_busy, 0);

    // flush with a multiply in the pipe and a divide running
    goto(120);
    issue(3'b001, 6'h09, 6'h07, 6'h08, 1, 0, 1'b0);
    issue(3'b110, 6'h33, 6'h09, 6'h0A, 1, 0, 1'b1);
    goto(123);
    flush = 1'b1;
    div_done = 1'b1;
    @(negedge clk);
    check("ack_in_flush", div_ack, 0);
    check("wb_in_flush", wb_vld, 0);
    tick();
    flush = 1'b0;
    div_done = 1'b0;
    @(negedge clk);
    check("kill_pulse", div_kill, 1);
    check("busy_after_flush", mc_busy, 0);
    tick();
    @(negedge clk);
    check("kill_one_cycle", div_kill, 0);

    goto(130);
    issue(3'b011, 6'h0C, 6'h11, 6'h12, 1, 1, 1'b0);

    // op presented together with flush is dropped
    goto(140);
    mc_vld = 1'b1;
    mc_op = 3'b000;
    mc_data = {6'h01, 6'h02, 6'h3F};
    flush = 1'b1;
    tick();
    mc_vld = 1'b0;
    mc_op = '0;
    mc_data = '0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_drop", mul_vld, 0);

    // asynchronous reset in the middle of a divide
    goto(158);
    issue(3'b001, 6'h1E, 6'h13, 6'h14, 1, 0, 1'b0);
    issue(3'b111, 6'h15, 6'h15, 6'h16, 0, 0, 1'b1);
    check("start_pre_rst", div_start, 1);
    check("busy_pre_rst", mc_busy, 1);
    rst = 1'b1;
    #1;
    check("arst_div_start", div_start, 0);
    check("arst_busy", mc_busy, 0);
    check("arst_div_op", div_op, 0);
    check("arst_div_rs1", div_rs1, 0);
    check("arst_mul_vld", mul_vld, 0);
    check("arst_wb_vld", wb_vld, 0);
    tick();
    rst = 1'b0;

    goto(170);
    issue(3'b010, 6'h22, 6'h17, 6'h18, 1, 1, 1'b0);

    goto(185);
    check("disp_queue_drained", dq.size(), 0);
    check("wb_queue_drained", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
